// File: rtl/demux_12_stream_if.sv
// Stream bundle for the 1:2 packet demultiplexer: one valid/ready input,
// two registered valid/ready output lanes, and status.
interface demux_12_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_sel;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] out0_data;
  logic             out0_last;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_last;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             busy;

  modport master (
    output in_data, in_valid, in_last, in_sel, mode, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_last, out0_valid,
           out1_data, out1_last, out1_valid, cnt0, cnt1, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, in_sel, mode, out0_ready, out1_ready,
    output in_ready, out0_data, out0_last, out0_valid,
           out1_data, out1_last, out1_valid, cnt0, cnt1, busy
  );
endinterface

// File: rtl/demux_12_stream.sv
// 1:2 packet-routing stream demultiplexer with one-entry registered output lanes.
// Destination is locked on the first word of each packet (select or ping-pong).
module demux_12_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  demux_12_stream_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;
  logic   r_dest, w_dest_nxt;
  logic   r_pkt_mode, w_pkt_mode_nxt;
  logic   r_alt_ptr, w_alt_ptr_nxt;

  logic       w_d;
  logic       w_mode_eff;
  logic       w_in_ready;
  logic       w_accept;
  logic [1:0] w_out_ready;
  logic [1:0] w_load;

  logic [1:0]       r_valid;
  logic [1:0]       r_last;
  logic [WIDTH-1:0] r_data [2];
  logic [CNT_W-1:0] r_cnt  [2];

  assign w_out_ready = {bus.out1_ready, bus.out0_ready};

  // First word routes on live inputs; later words follow the locked lane and mode.
  assign w_d        = (r_state == ST_IDLE) ? (bus.mode ? r_alt_ptr : bus.in_sel) : r_dest;
  assign w_mode_eff = (r_state == ST_IDLE) ? bus.mode : r_pkt_mode;

  // Only the destination lane gates the input, so a stalled other lane never blocks.
  assign w_in_ready = ~r_valid[w_d] | w_out_ready[w_d];
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_load     = w_accept ? (w_d ? 2'b10 : 2'b01) : 2'b00;

  // NOTE: every variable gets a default before the branches, otherwise a latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_dest_nxt     = r_dest;
    w_pkt_mode_nxt = r_pkt_mode;
    w_alt_ptr_nxt  = r_alt_ptr;
    if (w_accept) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!bus.in_last) begin
            w_state_nxt    = ST_BUSY;
            w_dest_nxt     = w_d;
            w_pkt_mode_nxt = bus.mode;
          end
        end
        ST_BUSY: begin
          if (bus.in_last) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      if (bus.in_last && w_mode_eff) w_alt_ptr_nxt = ~r_alt_ptr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dest     <= 1'b0;
      r_pkt_mode <= 1'b0;
      r_alt_ptr  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dest     <= w_dest_nxt;
      r_pkt_mode <= w_pkt_mode_nxt;
      r_alt_ptr  <= w_alt_ptr_nxt;
    end
  end

  // NOTE: these two-entry arrays are reset because the lane outputs must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_last  <= '0;
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= bus.in_data;
          r_last[i]  <= bus.in_last;
          r_cnt[i]   <= r_cnt[i] + CNT_W'(1);
        end else if (r_valid[i] && w_out_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out0_valid = r_valid[0];
  assign bus.out0_data  = r_data[0];
  assign bus.out0_last  = r_last[0];
  assign bus.out1_valid = r_valid[1];
  assign bus.out1_data  = r_data[1];
  assign bus.out1_last  = r_last[1];
  assign bus.cnt0       = r_cnt[0];
  assign bus.cnt1       = r_cnt[1];
  assign bus.busy       = (r_state == ST_BUSY);

endmodule
